alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//  Upstream control stage for datapath: holds a small program store, fetches one instruction at a time.
//  Drives ALUControl/addr1/addr2/addr3/wr so datapath executes rD = rA op rB, one register write per instruction.
//  Consumes datapath Zero/Overflow for branch-on-zero and a sticky overflow flag.
//  Start/done handshake to a host; program loaded via write port while idle.
// PARAMETERS
//  PROG_AW  4  program-store address width; depth = 2**PROG_AW instructions of 12 bits
//  REG_AW   2  register address width; must match regfile (4 registers)
// PORTS
//  clk         in   1        single clock, all state updates on posedge
//  rst         in   1        synchronous, active-high reset
//  start       in   1        run request; sampled only in IDLE
//  prog_we     in   1        program write strobe; honoured only in IDLE
//  prog_addr   in   PROG_AW  program write address
//  prog_data   in   12       instruction word to write
//  Zero        in   1        datapath Zero (combinational from ALU)
//  Overflow    in   1        datapath Overflow
//  ALUControl  out  3        ALU operation to datapath
//  addr1       out  REG_AW   source A register
//  addr2       out  REG_AW   source B register
//  addr3       out  REG_AW   destination register
//  wr          out  1        regfile write enable, one-cycle pulse
//  busy        out  1        high in FETCH/EXEC/WB
//  done        out  1        one-cycle pulse on HALT
//  pc          out  PROG_AW  current program counter
//  ovf_flag    out  1        sticky: any executed ALU instr overflowed since start
// BEHAVIOUR
//  Instr [11:10] class: 00 ALU, 01 NOP, 10 BRZ, 11 HALT; [9:7] ALUControl; [6:5] rA; [4:3] rB; [2:1] rD; [0] rsvd.
//  BRZ target = instr[PROG_AW-1:0].
//  Reset: state=IDLE, pc=0, IR=0, wr=0, done=0, busy=0, ovf_flag=0, z_flag=0;
//    ALUControl/addr*=0; program store NOT cleared.
//  FSM IDLE->FETCH on start; FETCH: IR<=mem[pc] -> EXEC.
//  EXEC: outputs driven from IR, wr=0; Zero/Overflow sampled at end of cycle.
//    ALU: z_flag<=Zero, ovf_flag|=Overflow -> WB.
//    NOP: pc+1 -> FETCH.  HALT: done=1 next cycle -> IDLE, pc held.
//    BRZ: pc<=z_flag?target:pc+1 -> FETCH.
//  WB: wr=1 exactly this cycle, addr/ALUControl held stable from EXEC; pc+1 -> FETCH.
//  Latency: start high in IDLE cycle n -> FETCH n+1, EXEC n+2, wr=1 in n+3. ALU=3 cycles, NOP/BRZ=2.
//  pc wraps 2**PROG_AW-1 -> 0 on increment; no halt implied by wrap.
//  start while busy ignored; prog_we while busy ignored (store unchanged).
//  start + prog_we same IDLE cycle: write completes; first FETCH sees new word.
//  On start: pc<=0, ovf_flag<=0, z_flag<=0.
//  rst mid-run: abandons instruction; wr deasserted same edge, no partial write.
//  Outputs registered; no combinational path from Zero/Overflow to any output.
// CONFIGURATION
//  ALU_SEQ_BRZ_EN defined: class 10 branches as above.
//  ALU_SEQ_BRZ_EN undefined: class 10 executes as NOP (2 cycles, pc+1); z_flag logic omitted.
// TESTING
//  1 rst=1 one cycle -> wr=0, busy=0, done=0, pc=0, ovf_flag=0 next cycle.
//  2 Load mem[0]=ALU XOR(011) rA=2 rB=0 rD=3, mem[1]=HALT; start
//    -> wr=1 exactly once at start+3 with ALUControl=011, addr1=2, addr2=0, addr3=3;
//    done pulse at start+6; busy low after.
//  3 Regs R1=R2=0x7FFFFFFF, ALU ADD R1+R2->R3 then HALT
//    -> ovf_flag=1 after EXEC, remains 1 until next start.
//  4 BRZ_EN: SUB R1-R1->R0 (Zero=1), BRZ 5, mem[5]=HALT
//    -> pc sequence 0,1,5; done. Without macro: pc 0,1,2.
//  5 prog_we to mem[0] while busy -> contents unchanged;
//    start asserted while busy -> no restart, pc unaffected.
//  6 rst asserted in WB cycle -> wr=0 and pc=0 after edge, no regfile write; new start runs from pc=0.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Host/datapath-facing bus of alu_sequencer: program load port, start/done handshake,
// datapath status inputs and ALU/regfile control outputs.
interface alu_sequencer_if #(
  parameter int PROG_AW = 4,
  parameter int REG_AW  = 2
);
  logic               start;
  logic               prog_we;
  logic [PROG_AW-1:0] prog_addr;
  logic [11:0]        prog_data;
  logic               Zero;
  logic               Overflow;
  logic [2:0]         ALUControl;
  logic [REG_AW-1:0]  addr1;
  logic [REG_AW-1:0]  addr2;
  logic [REG_AW-1:0]  addr3;
  logic               wr;
  logic               busy;
  logic               done;
  logic [PROG_AW-1:0] pc;
  logic               ovf_flag;

  modport master (
    output start, prog_we, prog_addr, prog_data, Zero, Overflow,
    input  ALUControl, addr1, addr2, addr3, wr, busy, done, pc, ovf_flag
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data, Zero, Overflow,
    output ALUControl, addr1, addr2, addr3, wr, busy, done, pc, ovf_flag
  );
endinterface

// File: rtl/alu_sequencer.sv
// Program sequencer for a regfile/ALU datapath: fetch, execute, write back one instruction at a time.
// Optional macro ALU_SEQ_BRZ_EN turns instruction class 10 into branch-on-zero (otherwise a NOP).
module alu_sequencer #(
  parameter int PROG_AW = 4,
  parameter int REG_AW  = 2
) (
  input  logic           clk,
  input  logic           rst,
  alu_sequencer_if.slave bus
);
  localparam int PROG_DEPTH = 2 ** PROG_AW;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_NOP = 2'b01;
  localparam logic [1:0] CLS_BRZ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WB
  } state_t;

  state_t             state_reg, state_next;
  logic [PROG_AW-1:0] pc_reg, pc_next;
  logic [11:0]        ir_reg;
  logic               ovf_reg, ovf_next;
  logic               done_reg, done_next;
  logic [11:0]        prog_mem [PROG_DEPTH];

  logic [1:0]         ir_class;
  logic [PROG_AW-1:0] pc_inc;

  assign ir_class = ir_reg[11:10];
  assign pc_inc   = pc_reg + PROG_AW'(1);

`ifdef ALU_SEQ_BRZ_EN
  logic z_reg, z_next;
`else
  logic unused_zero;
  assign unused_zero = bus.Zero;
`endif

  logic unused_rsvd;
  assign unused_rsvd = ir_reg[0];

  // Program store: writable only while idle so a running program never changes under itself.
  always_ff @(posedge clk) begin
    if (bus.prog_we && state_reg == S_IDLE) begin
      prog_mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
      ovf_reg   <= 1'b0;
      done_reg  <= 1'b0;
`ifdef ALU_SEQ_BRZ_EN
      z_reg     <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ovf_reg   <= ovf_next;
      done_reg  <= done_next;
`ifdef ALU_SEQ_BRZ_EN
      z_reg     <= z_next;
`endif
      if (state_reg == S_FETCH) begin
        ir_reg <= prog_mem[pc_reg];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ovf_next   = ovf_reg;
    done_next  = 1'b0;
`ifdef ALU_SEQ_BRZ_EN
    z_next     = z_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_FETCH;
          pc_next    = '0;
          ovf_next   = 1'b0;
`ifdef ALU_SEQ_BRZ_EN
          z_next     = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        state_next = S_EXEC;
      end
      S_EXEC: begin
        // Zero/Overflow only ever land in flags, never straight onto an output.
        case (ir_class)
          CLS_ALU: begin
            ovf_next   = ovf_reg | bus.Overflow;
`ifdef ALU_SEQ_BRZ_EN
            z_next     = bus.Zero;
`endif
            state_next = S_WB;
          end
          CLS_NOP: begin
            pc_next    = pc_inc;
            state_next = S_FETCH;
          end
          CLS_BRZ: begin
`ifdef ALU_SEQ_BRZ_EN
            pc_next    = z_reg ? ir_reg[PROG_AW-1:0] : pc_inc;
`else
            pc_next    = pc_inc;
`endif
            state_next = S_FETCH;
          end
          default: begin
            done_next  = 1'b1;
            state_next = S_IDLE;
          end
        endcase
      end
      S_WB: begin
        pc_next    = pc_inc;
        state_next = S_FETCH;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Operand/opcode fields come straight from IR, so they stay stable across EXEC and WB.
  assign bus.ALUControl = ir_reg[9:7];
  assign bus.addr1      = REG_AW'(ir_reg[6:5]);
  assign bus.addr2      = REG_AW'(ir_reg[4:3]);
  assign bus.addr3      = REG_AW'(ir_reg[2:1]);
  // Reset kills the write strobe in the same cycle so an abandoned WB never reaches the regfile.
  assign bus.wr         = (state_reg == S_WB) && !rst;
  assign bus.busy       = (state_reg != S_IDLE);
  assign bus.done       = done_reg;
  assign bus.pc         = pc_reg;
  assign bus.ovf_flag   = ovf_reg;

endmodule
